// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of the byte-addressed data memory.
// Each accepted request runs one DM access and returns a one-cycle response.
module dm_port_arbiter #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_we,
   input  logic [1:0]    req0_size,
   input  logic          req0_isu,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          resp0_valid,
   output logic [DW-1:0] resp0_rdata,
   output logic          resp0_err,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_we,
   input  logic [1:0]    req1_size,
   input  logic          req1_isu,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          resp1_valid,
   output logic [DW-1:0] resp1_rdata,
   output logic          resp1_err,
   output logic          dm_we,
   output logic [1:0]    dm_memdst,
   output logic          dm_isu,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] dm_rdata,
   output logic [7:0]    err_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          last_grant_q, last_grant_d;
   logic          we_q, we_d;
   logic          isu_q, isu_d;
   logic          err_q, err_d;
   logic [1:0]    size_q, size_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [7:0]    err_count_q, err_count_d;

   logic          any_valid, accept, sel, sel_err;
   logic [1:0]    sel_size;
   logic [AW-1:0] sel_addr;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A tie goes to the port that did not win the previous grant.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      accept    = (state_q == IDLE) & any_valid;
      sel       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
      sel_size  = sel ? req1_size : req0_size;
      sel_addr  = sel ? req1_addr : req0_addr;
      sel_err   = (sel_size == 2'd2) |
                  ((sel_size == 2'd1) & sel_addr[0]) |
                  ((sel_size == 2'd3) & (sel_addr[1:0] != 2'b00));
   end

   always_comb begin
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      isu_d        = isu_q;
      err_d        = err_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_count_d  = err_count_q;
      if (accept) begin
         gnt_d        = sel;
         last_grant_d = sel;
         we_d         = sel ? req1_we    : req0_we;
         isu_d        = sel ? req1_isu   : req0_isu;
         wdata_d      = sel ? req1_wdata : req0_wdata;
         size_d       = sel_size;
         addr_d       = sel_addr;
         err_d        = sel_err;
      end
      if (state_q == ACCESS) begin
         rdata_d = (we_q | err_q) ? '0 : dm_rdata;
         if (err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         isu_q        <= 1'b0;
         err_q        <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_count_q  <= '0;
      end else begin
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         isu_q        <= isu_d;
         err_q        <= err_d;
         size_q       <= size_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         err_count_q  <= err_count_d;
      end
   end

   // Reset is folded into dm_we so a store abandoned mid-access never reaches the DM.
   always_comb begin
      req0_ready  = accept & ~sel;
      req1_ready  = accept & sel;
      dm_we       = 1'b0;
      dm_memdst   = '0;
      dm_isu      = 1'b0;
      dm_addr     = '0;
      dm_wdata    = '0;
      resp0_valid = 1'b0;
      resp0_rdata = '0;
      resp0_err   = 1'b0;
      resp1_valid = 1'b0;
      resp1_rdata = '0;
      resp1_err   = 1'b0;
      err_count   = err_count_q;
      if (state_q == ACCESS) begin
         dm_we     = we_q & ~err_q & ~reset;
         dm_memdst = size_q;
         dm_isu    = isu_q;
         dm_addr   = addr_q;
         dm_wdata  = wdata_q;
      end
      if (state_q == RESP) begin
         if (gnt_q) begin
            resp1_valid = 1'b1;
            resp1_rdata = rdata_q;
            resp1_err   = err_q;
         end else begin
            resp0_valid = 1'b1;
            resp0_rdata = rdata_q;
            resp0_err   = err_q;
         end
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: vector table of single transactions plus
// hand sequences for round-robin ties, reset during access and error saturation.
module tb_dm_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req0_we, req0_isu;
   logic [1:0]  req0_size;
   logic [11:0] req0_addr;
   logic [31:0] req0_wdata;
   logic        resp0_valid, resp0_err;
   logic [31:0] resp0_rdata;
   logic        req1_valid, req1_ready, req1_we, req1_isu;
   logic [1:0]  req1_size;
   logic [11:0] req1_addr;
   logic [31:0] req1_wdata;
   logic        resp1_valid, resp1_err;
   logic [31:0] resp1_rdata;
   logic        dm_we, dm_isu;
   logic [1:0]  dm_memdst;
   logic [11:0] dm_addr;
   logic [31:0] dm_wdata, dm_rdata;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dm_port_arbiter #(.AW(12), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_size(req0_size), .req0_isu(req0_isu), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
      .resp0_err(resp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_size(req1_size), .req1_isu(req1_isu), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
      .resp1_err(resp1_err),
      .dm_we(dm_we), .dm_memdst(dm_memdst), .dm_isu(dm_isu), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .err_count(err_count)
   );

   // Data memory model: little-endian bytes, combinational extended read.
   logic [7:0]  mem [0:4095] = '{default: 8'h00};
   logic [11:0] a1, a2, a3;
   logic [7:0]  b0, b1, b2, b3;
   assign a1 = dm_addr + 12'd1;
   assign a2 = dm_addr + 12'd2;
   assign a3 = dm_addr + 12'd3;
   assign b0 = mem[dm_addr];
   assign b1 = mem[a1];
   assign b2 = mem[a2];
   assign b3 = mem[a3];

   always_comb begin
      dm_rdata = '0;
      case (dm_memdst)
         2'd0: dm_rdata = dm_isu ? {24'd0, b0} : {{24{b0[7]}}, b0};
         2'd1: dm_rdata = dm_isu ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
         2'd3: dm_rdata = {b3, b2, b1, b0};
         default: dm_rdata = '0;
      endcase
   end

   always @(posedge clk) begin
      if (dm_we) begin
         case (dm_memdst)
            2'd0: mem[dm_addr] <= dm_wdata[7:0];
            2'd1: begin mem[dm_addr] <= dm_wdata[7:0]; mem[a1] <= dm_wdata[15:8]; end
            2'd3: begin
               mem[dm_addr] <= dm_wdata[7:0];   mem[a1] <= dm_wdata[15:8];
               mem[a2]      <= dm_wdata[23:16]; mem[a3] <= dm_wdata[31:24];
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
      end
   endtask

   task automatic set_req(input int p, input logic v, input logic we, input logic [1:0] sz,
                          input logic isu, input logic [11:0] a, input logic [31:0] wd);
      if (p == 0) begin
         req0_valid = v; req0_we = we; req0_size = sz; req0_isu = isu;
         req0_addr = a; req0_wdata = wd;
      end else begin
         req1_valid = v; req1_we = we; req1_size = sz; req1_isu = isu;
         req1_addr = a; req1_wdata = wd;
      end
   endtask

   task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic isu,
                         input logic [11:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
      int   cyc;
      logic rdy;
      cyc = 0;
      @(negedge clk);
      set_req(p, 1'b1, we, sz, isu, a, wd);
      #1;
      rdy = (p == 0) ? req0_ready : req1_ready;
      while (!rdy && cyc < 10) begin
         @(negedge clk); #1;
         rdy = (p == 0) ? req0_ready : req1_ready;
         cyc++;
      end
      chk("ready", {31'd0, rdy}, 32'd1);
      chk("other_ready", {31'd0, (p == 0) ? req1_ready : req0_ready}, 32'd0);
      if (!rdy) begin
         set_req(p, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
         return;
      end
      @(negedge clk);
      set_req(p, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
      #1;
      chk("dm_we", {31'd0, dm_we}, {31'd0, we & ~exp_err});
      chk("dm_memdst", {30'd0, dm_memdst}, {30'd0, sz});
      chk("dm_addr", {20'd0, dm_addr}, {20'd0, a});
      if (we) chk("dm_wdata", dm_wdata, wd);
      @(negedge clk); #1;
      chk("resp_valid", {31'd0, (p == 0) ? resp0_valid : resp1_valid}, 32'd1);
      chk("other_resp", {31'd0, (p == 0) ? resp1_valid : resp0_valid}, 32'd0);
      chk("resp_err", {31'd0, (p == 0) ? resp0_err : resp1_err}, {31'd0, exp_err});
      chk("resp_rdata", (p == 0) ? resp0_rdata : resp1_rdata, exp_rd);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      int          port;
      logic        we;
      logic [1:0]  size;
      logic        isu;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [14];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   grants;
      int   exp_order [4];
      logic seen_resp;
      logic w;

      vecs[0]  = '{0, 1'b1, 2'd3, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{1, 1'b0, 2'd0, 1'b0, 12'h010, 32'h0,        32'hFFFFFFEF, 1'b0};
      vecs[2]  = '{1, 1'b0, 2'd0, 1'b1, 12'h010, 32'h0,        32'h000000EF, 1'b0};
      vecs[3]  = '{0, 1'b0, 2'd1, 1'b0, 12'h012, 32'h0,        32'hFFFFDEAD, 1'b0};
      vecs[4]  = '{1, 1'b0, 2'd1, 1'b1, 12'h012, 32'h0,        32'h0000DEAD, 1'b0};
      vecs[5]  = '{0, 1'b0, 2'd3, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1, 1'b1, 2'd0, 1'b0, 12'h021, 32'h1234565A, 32'h00000000, 1'b0};
      vecs[7]  = '{0, 1'b0, 2'd0, 1'b1, 12'h021, 32'h0,        32'h0000005A, 1'b0};
      vecs[8]  = '{1, 1'b0, 2'd3, 1'b0, 12'h020, 32'h0,        32'h00005A00, 1'b0};
      vecs[9]  = '{0, 1'b1, 2'd1, 1'b0, 12'h003, 32'h0000AAAA, 32'h00000000, 1'b1};
      vecs[10] = '{0, 1'b1, 2'd3, 1'b0, 12'h002, 32'h55555555, 32'h00000000, 1'b1};
      vecs[11] = '{0, 1'b0, 2'd2, 1'b0, 12'h000, 32'h0,        32'h00000000, 1'b1};
      vecs[12] = '{1, 1'b1, 2'd3, 1'b0, 12'hFFC, 32'hCAFEF00D, 32'h00000000, 1'b0};
      vecs[13] = '{1, 1'b0, 2'd3, 1'b0, 12'hFFC, 32'h0,        32'hCAFEF00D, 1'b0};
      exp_order = '{0, 1, 0, 1};

      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_outputs_zero", {31'd0, |{req0_ready, req1_ready, resp0_valid, resp0_rdata,
          resp0_err, resp1_valid, resp1_rdata, resp1_err, dm_we, dm_memdst, dm_isu, dm_addr,
          dm_wdata}}, 32'd0);
      chk("reset_err_count", {24'd0, err_count}, 32'd0);

      for (int i = 0; i < 14; i++)
         do_req(vecs[i].port, vecs[i].we, vecs[i].size, vecs[i].isu, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
      #1;
      chk("err_count_after_table", {24'd0, err_count}, 32'd3);
      chk("mem_not_written_by_err", {mem[3], mem[4], mem[2], mem[5]}, 32'd0);

      // Both ports request continuously after reset: grants must alternate from port 0.
      do_reset();
      set_req(0, 1'b1, 1'b0, 2'd3, 1'b0, 12'h010, 32'd0);
      set_req(1, 1'b1, 1'b0, 2'd3, 1'b0, 12'h010, 32'd0);
      grants = 0;
      for (int c = 0; c < 60 && grants < 4; c++) begin
         #1;
         if (req0_ready | req1_ready) begin
            chk("single_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            chk("grant_order", {31'd0, req1_ready}, exp_order[grants][31:0]);
            grants++;
         end
         @(negedge clk);
      end
      chk("tie_grants_done", grants, 32'd4);
      set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
      repeat (4) @(negedge clk);

      // Reset arriving during the ACCESS cycle of a store.
      set_req(0, 1'b1, 1'b1, 2'd3, 1'b0, 12'h030, 32'h11223344);
      #1;
      chk("rst_store_ready", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
      #1;
      w = dm_we;
      chk("rst_store_access", {30'd0, dm_memdst}, 32'd3);
      reset = 1'b1;
      #1;
      chk("rst_store_we_gated", {31'd0, dm_we}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_store_we_pre", {31'd0, w}, 32'd1);
      chk("rst_outputs_zero", {31'd0, |{req0_ready, req1_ready, resp0_valid, resp0_rdata,
          resp0_err, resp1_valid, resp1_rdata, resp1_err, dm_we, dm_memdst, dm_isu, dm_addr,
          dm_wdata, err_count}}, 32'd0);
      seen_resp = 1'b0;
      for (int c = 0; c < 4; c++) begin
         seen_resp = seen_resp | resp0_valid | resp1_valid | dm_we;
         @(negedge clk); #1;
      end
      chk("rst_no_resp", {31'd0, seen_resp}, 32'd0);
      chk("rst_dm_unchanged", {mem[12'h033], mem[12'h032], mem[12'h031], mem[12'h030]}, 32'd0);

      // Saturation: 300 illegal-size requests alternating ports.
      for (int i = 0; i < 300; i++) begin
         do_req(i % 2, 1'b1, 2'd2, 1'b0, 12'h040, 32'hFFFFFFFF, 32'd0, 1'b1);
         if (i == 253) begin
            #1;
            chk("err_count_254", {24'd0, err_count}, 32'd254);
         end
      end
      repeat (2) @(negedge clk);
      #1;
      chk("err_count_saturated", {24'd0, err_count}, 32'd255);
      chk("sat_mem_untouched", {mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
